// File: rtl/sb8_child_dispatcher.sv
// Purpose: accepts one work item on a valid/ready input and dispatches it to one enabled
//          sb8 child, rotating round-robin; counts dispatches (saturating) and flags
//          items that arrive while no child is enabled.
// Latency: accept at edge t -> out_valid high after edge t; minimum 2 cycles per item.
// Backpressure: in_ready is low while an item waits in SEND; out_valid is held until
//               the targeted child's out_ready completes the handshake.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_valid/in_ready      upstream handshake, in_data payload
//   child_en               per-child enable mask, looked at only on accept
//   out_valid/out_ready    per-child handshake (out_valid zero-or-one-hot)
//   out_data, out_idx      held payload and index of the current target
//   dispatch_cnt           saturating count of completed dispatches
//   err_no_target          one-cycle pulse when an item is dropped (empty mask)
module sb8_child_dispatcher #(
  parameter int NUM_CHILDREN = 5,
  parameter int DATA_W       = 16,
  parameter int CNT_W        = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [NUM_CHILDREN-1:0] child_en,
  output logic [NUM_CHILDREN-1:0] out_valid,
  input  logic [NUM_CHILDREN-1:0] out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [2:0]              out_idx,
  output logic [CNT_W-1:0]        dispatch_cnt,
  output logic                    err_no_target
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [NUM_CHILDREN-1:0] ONE_HOT0 = {{(NUM_CHILDREN-1){1'b0}}, 1'b1};

  state_t                    state;
  logic [2:0]                rr_ptr;
  logic [2*NUM_CHILDREN-1:0] dbl_en;
  logic [2*NUM_CHILDREN-1:0] shifted_en;
  logic [NUM_CHILDREN-1:0]   rot_en;
  logic                      found;
  logic [3:0]                sum;
  logic [2:0]                target;
  logic                      handshake;

  assign in_ready  = (state == IDLE);
  // out_valid is one-hot on out_idx, so any overlap with out_ready is the handshake
  assign handshake = |(out_valid & out_ready);

  // Round-robin search: rotate the mask so bit 0 is rr_ptr, pick the lowest set bit,
  // then map the offset back to an absolute child index modulo NUM_CHILDREN.
  always_comb begin
    dbl_en     = {child_en, child_en};
    shifted_en = dbl_en >> rr_ptr;
    rot_en     = shifted_en[NUM_CHILDREN-1:0];
    found      = |rot_en;
    sum        = {1'b0, rr_ptr};
    for (int k = NUM_CHILDREN - 1; k >= 0; k--) begin
      if (rot_en[k]) sum = {1'b0, rr_ptr} + 4'(k);
    end
    if (sum >= 4'(NUM_CHILDREN)) sum = sum - 4'(NUM_CHILDREN);
    target = sum[2:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      out_valid     <= '0;
      out_data      <= '0;
      out_idx       <= '0;
      dispatch_cnt  <= '0;
      err_no_target <= 1'b0;
    end else begin
      err_no_target <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            out_data <= in_data;
            if (found) begin
              out_idx   <= target;
              out_valid <= ONE_HOT0 << target;
              state     <= SEND;
            end else begin
              err_no_target <= 1'b1;
            end
          end
        end
        SEND: begin
          if (handshake) begin
            out_valid <= '0;
            state     <= IDLE;
            rr_ptr    <= (out_idx == 3'(NUM_CHILDREN - 1)) ? 3'd0 : out_idx + 3'd1;
            if (dispatch_cnt != {CNT_W{1'b1}}) dispatch_cnt <= dispatch_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sb8_child_dispatcher.sv
// Bench for sb8_child_dispatcher: a transaction-level model (busy flag, target, pointer,
// count) predicts every output each cycle; a second instance with a 3-bit counter shares
// the stimulus to cover saturation.
module tb_sb8_child_dispatcher;
  localparam int N = 5;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [N-1:0]  child_en;
  logic [N-1:0]  out_valid;
  logic [N-1:0]  out_ready;
  logic [DW-1:0] out_data;
  logic [2:0]    out_idx;
  logic [7:0]    dispatch_cnt;
  logic          err_no_target;

  logic          s_in_ready;
  logic [N-1:0]  s_out_valid;
  logic [DW-1:0] s_out_data;
  logic [2:0]    s_out_idx;
  logic [2:0]    s_cnt;
  logic          s_err;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit        m_busy;
  int        m_tgt;
  int        m_rr;
  int        m_cnt;
  bit        m_err;
  bit [DW-1:0] m_dat;

  always #5 clk = ~clk;

  sb8_child_dispatcher #(.NUM_CHILDREN(N), .DATA_W(DW), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .child_en(child_en), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .dispatch_cnt(dispatch_cnt), .err_no_target(err_no_target)
  );

  sb8_child_dispatcher #(.NUM_CHILDREN(N), .DATA_W(DW), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .child_en(child_en), .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_idx(s_out_idx), .dispatch_cnt(s_cnt), .err_no_target(s_err)
  );

  always @(negedge clk) begin
    if (!rst) assert ($onehot0(out_valid))
      else $error("FAIL onehot out_valid=%b", out_valid);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_tgt = 0; m_rr = 0; m_cnt = 0; m_err = 0; m_dat = '0;
  endtask

  // Advance the model by one rising edge, using the inputs present before the edge.
  task automatic model_edge();
    bit hit;
    m_err = 0;
    if (rst) begin
      model_reset();
    end else if (!m_busy) begin
      if (in_valid) begin
        hit = 0;
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_rr + k) % N;
          if (!hit && child_en[j]) begin
            hit = 1;
            m_tgt = j;
          end
        end
        if (hit) begin
          m_busy = 1;
          m_dat = in_data;
        end else begin
          m_err = 1;
        end
      end
    end else if (out_ready[m_tgt]) begin
      m_busy = 0;
      m_rr = (m_tgt + 1) % N;
      m_cnt++;
    end
  endtask

  task automatic check_all();
    chk("in_ready", in_ready, !m_busy);
    chk("out_valid", out_valid, m_busy ? (32'd1 << m_tgt) : 32'd0);
    if (m_busy) begin
      chk("out_data", out_data, m_dat);
      chk("out_idx", out_idx, m_tgt);
    end
    chk("dispatch_cnt", dispatch_cnt, (m_cnt > 255) ? 255 : m_cnt);
    chk("sat_cnt", s_cnt, (m_cnt > 7) ? 7 : m_cnt);
    chk("err_no_target", err_no_target, m_err);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  // Accept one item and complete it on the following edge (out_ready all high).
  task automatic send_item(input logic [DW-1:0] d, input int exp_tgt, input string tag);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
    chk(tag, out_idx, exp_tgt);
    step();
  endtask

  initial begin
    int exp_rr[6];
    int exp_sp[4];
    exp_rr = '{0, 1, 2, 3, 4, 0};
    exp_sp = '{2, 4, 2, 4};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; child_en = '0; out_ready = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_cnt", dispatch_cnt, 0);
    chk("rst_err", err_no_target, 0);

    // round robin over full mask
    child_en = 5'b11111; out_ready = 5'b11111;
    for (int i = 0; i < 6; i++) send_item(16'h00A0 + 16'(i), exp_rr[i], "rr_full_tgt");
    chk("rr_full_cnt", dispatch_cnt, 6);

    // sparse mask
    child_en = 5'b10100;
    for (int i = 0; i < 4; i++) send_item(16'h0B00 + 16'(i), exp_sp[i], "sparse_tgt");
    chk("sparse_cnt", dispatch_cnt, 10);

    // backpressure on child 0
    child_en = 5'b11111; out_ready = 5'b11110;
    in_valid = 1'b1; in_data = 16'hBEEF;
    step();
    in_valid = 1'b0;
    repeat (10) begin
      chk("bp_out_valid", out_valid, 5'b00001);
      chk("bp_out_data", out_data, 16'hBEEF);
      chk("bp_in_ready", in_ready, 0);
      child_en = 5'($urandom);
      out_ready[4:1] = 4'($urandom);
      step();
    end
    out_ready = 5'b11111; child_en = 5'b11111;
    step();
    chk("bp_release", in_ready, 1);
    send_item(16'h1234, 1, "bp_next_tgt");

    // empty mask drop
    child_en = 5'b00000;
    in_valid = 1'b1; in_data = 16'hDEAD;
    step();
    in_valid = 1'b0;
    chk("empty_err", err_no_target, 1);
    chk("empty_valid", out_valid, 0);
    step();
    chk("empty_err_clear", err_no_target, 0);
    child_en = 5'b11111;
    send_item(16'h5555, 2, "empty_next_tgt");
    chk("empty_cnt", dispatch_cnt, 13);

    // saturation of the 3-bit counter instance
    chk("sat_stop", s_cnt, 7);

    // asynchronous reset in the middle of SEND
    out_ready = '0;
    in_valid = 1'b1; in_data = 16'h7777;
    step();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_cnt", dispatch_cnt, 0);
    model_reset();
    step();
    rst = 1'b0;
    out_ready = 5'b11111;
    send_item(16'h0042, 0, "post_rst_tgt");

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 16'($urandom);
      child_en  = ($urandom_range(0, 9) == 0) ? 5'b0 : 5'($urandom);
      out_ready = 5'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
